// File: rtl/vxc_pkg.sv
// Shared definitions for the VXC chunk sequencer: parameter defaults and the
// FSM state encoding used by the sequencer and its helpers.
package vxc_pkg;

    localparam int VXC_ELEMENT_WIDTH = 64;
    localparam int VXC_NI            = 8;
    localparam int VXC_PIPE_LAT      = 7;

    typedef logic [1:0] vxc_state_t;

    localparam vxc_state_t ST_IDLE  = 2'd0;
    localparam vxc_state_t ST_ISSUE = 2'd1;
    localparam vxc_state_t ST_DRAIN = 2'd2;
    localparam vxc_state_t ST_DONE  = 2'd3;

    // Number of NI-lane chunks needed to cover num elements.
    function automatic int vxc_ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/vxc_valid_pipe.sv
// Fixed-latency shift register carrying a valid flag and a payload
// (chunk address, plus the lane mask when that feature is built in).
// Asserting clear empties every stage on the next rising edge.
module vxc_valid_pipe
    import vxc_pkg::*;
#(
    parameter int DEPTH = VXC_PIPE_LAT,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    if (DEPTH < 1) begin : g_depth_check
        $error("vxc_valid_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] valid_q;
    logic [DW-1:0]    data_q [DEPTH];

    // Valid bits advance one stage per cycle and are wiped by clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // NOTE: the payload is only meaningful alongside its valid bit, so these
    // stages are deliberately left without a reset.
    always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/vxc_chunk_sequencer.sv
// Chunk sequencer: walks a NOE-element complex vector in NI-lane chunks,
// feeds operands to a fixed-latency multiply-add datapath and writes each
// result back to the chunk it came from.
// Optional feature: define VXC_SEQ_WRMASK_EN to add a per-lane write mask
// output that disables the padded lanes of the last chunk.
module vxc_chunk_sequencer
    import vxc_pkg::*;
#(
    parameter int NOE           = 19,
    parameter int NI            = VXC_NI,
    parameter int ELEMENT_WIDTH = VXC_ELEMENT_WIDTH,
    parameter int AW            = 8,
    parameter int PIPE_LAT      = VXC_PIPE_LAT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        op_in,
    input  logic [ELEMENT_WIDTH-1:0]    constant_in,
    output logic                        rd_en,
    output logic [AW-1:0]               rd_addr,
    input  logic [ELEMENT_WIDTH*NI-1:0] rd_data_a,
    input  logic [ELEMENT_WIDTH*NI-1:0] rd_data_b,
    output logic [ELEMENT_WIDTH*NI-1:0] first_row_input,
    output logic [ELEMENT_WIDTH*NI-1:0] second_row_input,
    output logic [ELEMENT_WIDTH-1:0]    constant,
    output logic                        op,
    input  logic [ELEMENT_WIDTH*NI-1:0] result,
    output logic                        wr_en,
    output logic [AW-1:0]               wr_addr,
    output logic [ELEMENT_WIDTH*NI-1:0] wr_data,
    output logic                        busy,
    output logic                        done
`ifdef VXC_SEQ_WRMASK_EN
    ,
    output logic [NI-1:0]               wr_mask
`endif
);

    localparam int EW     = ELEMENT_WIDTH;
    localparam int LW     = ELEMENT_WIDTH * NI;
    localparam int CHUNKS = vxc_ceil_div(NOE, NI);
    localparam int REM    = NOE % NI;

    localparam logic [AW-1:0] LAST_ADDR = AW'(CHUNKS - 1);
    localparam logic [NI-1:0] FULL_MASK = '1;
    // Lane j lives in slot NI-1-j, so the surviving lanes 0..REM-1 are the
    // top REM bits of the mask.
    localparam logic [NI-1:0] LAST_MASK = (REM == 0) ? FULL_MASK
                                                     : FULL_MASK << (NI - REM);

    if (NOE < 1) begin : g_noe_check
        $error("vxc_chunk_sequencer: NOE must be at least 1");
    end
    if (CHUNKS > (1 << AW)) begin : g_aw_check
        $error("vxc_chunk_sequencer: AW too small for the chunk count");
    end

`ifdef VXC_SEQ_WRMASK_EN
    localparam int PW = AW + NI;
`else
    localparam int PW = AW;
`endif

    vxc_state_t     state_q;

    logic           data_valid_q;
    logic [AW-1:0]  data_addr_q;
    logic           opnd_valid_q;
    logic [AW-1:0]  opnd_addr_q;

    logic [NI-1:0]  lane_mask;
    logic [LW-1:0]  a_masked;
    logic [LW-1:0]  b_masked;

    logic [PW-1:0]  pipe_in;
    logic [PW-1:0]  pipe_out;
    logic           pipe_valid;
    logic [AW-1:0]  pipe_addr;

    assign busy = (state_q != ST_IDLE);

    // Control FSM: accepts start, issues one read per chunk, waits for the
    // final write-back and emits the completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            op       <= 1'b0;
            constant <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_ISSUE;
                        rd_en    <= 1'b1;
                        rd_addr  <= '0;
                        op       <= op_in;
                        constant <= constant_in;
                    end
                end
                ST_ISSUE: begin
                    if (rd_addr == LAST_ADDR) begin
                        state_q <= ST_DRAIN;
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                    end else begin
                        rd_addr <= rd_addr + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (wr_en && (wr_addr == LAST_ADDR)) begin
                        state_q <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero the padded lanes of the last chunk before they reach the datapath.
    // NOTE: combinational logic uses blocking assignments and gives every
    // output a default first, so no latch can be inferred.
    always_comb begin
        lane_mask = (data_addr_q == LAST_ADDR) ? LAST_MASK : FULL_MASK;
        a_masked  = '0;
        b_masked  = '0;
        for (int k = 0; k < NI; k++) begin
            if (lane_mask[k]) begin
                a_masked[k*EW +: EW] = rd_data_a[k*EW +: EW];
                b_masked[k*EW +: EW] = rd_data_b[k*EW +: EW];
            end
        end
    end

    // Read-return tracking and the registered operand stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_valid_q     <= 1'b0;
            data_addr_q      <= '0;
            opnd_valid_q     <= 1'b0;
            opnd_addr_q      <= '0;
            first_row_input  <= '0;
            second_row_input <= '0;
        end else begin
            data_valid_q <= rd_en;
            data_addr_q  <= rd_addr;
            opnd_valid_q <= data_valid_q;
            if (data_valid_q) begin
                opnd_addr_q      <= data_addr_q;
                first_row_input  <= a_masked;
                second_row_input <= b_masked;
            end
        end
    end

`ifdef VXC_SEQ_WRMASK_EN
    logic [NI-1:0] opnd_mask_q;
    logic [NI-1:0] pipe_mask;

    // Lane mask travels with the operands it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            opnd_mask_q <= '0;
        end else if (data_valid_q) begin
            opnd_mask_q <= lane_mask;
        end
    end

    assign pipe_in                = {opnd_addr_q, opnd_mask_q};
    assign {pipe_addr, pipe_mask} = pipe_out;
`else
    assign pipe_in   = opnd_addr_q;
    assign pipe_addr = pipe_out;
`endif

    vxc_valid_pipe #(
        .DEPTH (PIPE_LAT),
        .DW    (PW)
    ) u_valid_pipe (
        .clk       (clk),
        .clear     (reset),
        .in_valid  (opnd_valid_q),
        .in_data   (pipe_in),
        .out_valid (pipe_valid),
        .out_data  (pipe_out)
    );

    // Registered write-back of the datapath result to its source chunk.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
`ifdef VXC_SEQ_WRMASK_EN
            wr_mask <= '0;
`endif
        end else begin
            wr_en <= pipe_valid;
            if (pipe_valid) begin
                wr_addr <= pipe_addr;
                wr_data <= result;
`ifdef VXC_SEQ_WRMASK_EN
                wr_mask <= pipe_mask;
`endif
            end
        end
    end

endmodule

// File: tb/tb_vxc_chunk_sequencer.sv
// Scoreboard bench for vxc_chunk_sequencer. Two instances (NOE=19 with a
// padded last chunk, NOE=16 without padding) share one stimulus stream.
// Expected events are derived from the pass start cycle and pushed into
// queues; a per-instance monitor pops them as the DUT produces outputs.
module tb_vxc_chunk_sequencer;
    import vxc_pkg::*;

    localparam int EW = VXC_ELEMENT_WIDTH;
    localparam int NI = VXC_NI;
    localparam int L  = VXC_PIPE_LAT;
    localparam int AW = 8;
    localparam int LW = EW * NI;

    typedef struct { int cyc; int addr; } rd_exp_t;
    typedef struct { int cyc; logic [LW-1:0] a; logic [LW-1:0] b; } opnd_exp_t;
    typedef struct { int cyc; int addr; logic [LW-1:0] data; logic [NI-1:0] mask; } wr_exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op_in;
    logic [EW-1:0] constant_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_on  = 1'b0;
    bit drain_req = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Stand-in for the downstream multiply-add: any fixed function of the
    // operands, constant and op will do, as long as zero lanes stay visible.
    function automatic logic [LW-1:0] downstream(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                                 input logic [EW-1:0] k, input logic o);
        logic [LW-1:0] r;
        r = a ^ {b[LW-2:0], b[LW-1]} ^ {NI{k}};
        return o ? ~r : r;
    endfunction

    function automatic logic [LW-1:0] rand_chunk();
        logic [LW-1:0] v;
        for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int NOE = (g == 0) ? 19 : 16;
        localparam int CH  = (NOE + NI - 1) / NI;

        logic          rd_en, op, wr_en, busy, done;
        logic [AW-1:0] rd_addr, wr_addr;
        logic [LW-1:0] rd_data_a, rd_data_b, fri, sri, result, wr_data;
        logic [EW-1:0] constant;
`ifdef VXC_SEQ_WRMASK_EN
        logic [NI-1:0] wr_mask;
`endif

        vxc_chunk_sequencer #(
            .NOE(NOE), .NI(NI), .ELEMENT_WIDTH(EW), .AW(AW), .PIPE_LAT(L)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start), .op_in(op_in),
            .constant_in(constant_in), .rd_en(rd_en), .rd_addr(rd_addr),
            .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
            .first_row_input(fri), .second_row_input(sri),
            .constant(constant), .op(op), .result(result),
            .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
            .busy(busy), .done(done)
`ifdef VXC_SEQ_WRMASK_EN
            , .wr_mask(wr_mask)
`endif
        );

        string         tag = (g == 0) ? "noe19" : "noe16";
        logic [LW-1:0] mem_a [CH];
        logic [LW-1:0] mem_b [CH];
        logic [LW-1:0] ring  [16];
        bit            prev_rd = 1'b0;
        int            prev_addr = 0;

        rd_exp_t   rdq[$];
        opnd_exp_t opq[$];
        wr_exp_t   wrq[$];
        int        doneq[$];
        rd_exp_t   re;
        opnd_exp_t oe;
        wr_exp_t   we;
        int        de;
        int        busy_from = 1, busy_until = -1, zchk = -1;
        logic          exp_op;
        logic [EW-1:0] exp_k;
        logic [LW-1:0] ea, eb;
        logic [NI-1:0] em;
        bit            in_pass;

        // Environment: chunk memory with one-cycle read latency, and the
        // PIPE_LAT-cycle downstream datapath.
        always @(negedge clk) begin
            rd_data_a = prev_rd ? mem_a[prev_addr] : rand_chunk();
            rd_data_b = prev_rd ? mem_b[prev_addr] : rand_chunk();
            prev_rd   = rd_en;
            prev_addr = int'(rd_addr);
            ring[cyc % 16] = downstream(fri, sri, constant, op);
            result = ring[(cyc + 16 - L) % 16];
        end

        // Monitor first, then the reference model reacts to this cycle's inputs.
        always @(negedge clk) begin
            if (mon_on) begin
                if (rd_en) begin
                    if (rdq.size() == 0) check({tag, " unexpected rd_en"}, rd_en, 1'b0);
                    else begin
                        re = rdq.pop_front();
                        check({tag, " rd cycle"}, cyc, re.cyc);
                        check({tag, " rd_addr"}, rd_addr, re.addr);
                    end
                end
                if (opq.size() != 0 && opq[0].cyc == cyc) begin
                    oe = opq.pop_front();
                    check({tag, " first_row_input"}, fri, oe.a);
                    check({tag, " second_row_input"}, sri, oe.b);
                end
                if (wr_en) begin
                    if (wrq.size() == 0) check({tag, " unexpected wr_en"}, wr_en, 1'b0);
                    else begin
                        we = wrq.pop_front();
                        check({tag, " wr cycle"}, cyc, we.cyc);
                        check({tag, " wr_addr"}, wr_addr, we.addr);
                        check({tag, " wr_data"}, wr_data, we.data);
`ifdef VXC_SEQ_WRMASK_EN
                        check({tag, " wr_mask"}, wr_mask, we.mask);
`endif
                    end
                end
                if (done) begin
                    if (doneq.size() == 0) check({tag, " unexpected done"}, done, 1'b0);
                    else begin
                        de = doneq.pop_front();
                        check({tag, " done cycle"}, cyc, de);
                    end
                end
                in_pass = (cyc >= busy_from) && (cyc <= busy_until);
                check({tag, " busy"}, busy, in_pass);
                if (in_pass) begin
                    check({tag, " op held"}, op, exp_op);
                    check({tag, " constant held"}, constant, exp_k);
                end
                if (cyc == zchk) begin
                    check({tag, " reset rd_en/rd_addr"}, {rd_en, rd_addr}, '0);
                    check({tag, " reset operands"}, fri | sri, '0);
                    check({tag, " reset constant/op"}, {constant, op}, '0);
                    check({tag, " reset wr_en/wr_addr/busy/done"}, {wr_en, wr_addr, busy, done}, '0);
                    check({tag, " reset wr_data"}, wr_data, '0);
                end
                if (drain_req) begin
                    check({tag, " pending reads"}, rdq.size(), 0);
                    check({tag, " pending writes"}, wrq.size(), 0);
                    check({tag, " pending done"}, doneq.size(), 0);
                end
            end

            if (reset) begin
                // Everything scheduled after this cycle is discarded.
                while (rdq.size() > 0 && rdq[rdq.size()-1].cyc > cyc) void'(rdq.pop_back());
                while (opq.size() > 0 && opq[opq.size()-1].cyc > cyc) void'(opq.pop_back());
                while (wrq.size() > 0 && wrq[wrq.size()-1].cyc > cyc) void'(wrq.pop_back());
                while (doneq.size() > 0 && doneq[doneq.size()-1] > cyc) void'(doneq.pop_back());
                if (busy_until >= cyc) busy_until = cyc;
                zchk = cyc + 1;
            end else if (start && cyc > busy_until) begin
                exp_op     = op_in;
                exp_k      = constant_in;
                busy_from  = cyc + 1;
                busy_until = cyc + L + 4 + CH;
                for (int i = 0; i < CH; i++) begin
                    mem_a[i] = rand_chunk();
                    mem_b[i] = rand_chunk();
                    ea = '0; eb = '0; em = '0;
                    for (int j = 0; j < NI; j++) begin
                        if (i * NI + j < NOE) begin
                            ea[(NI-1-j)*EW +: EW] = mem_a[i][(NI-1-j)*EW +: EW];
                            eb[(NI-1-j)*EW +: EW] = mem_b[i][(NI-1-j)*EW +: EW];
                            em[NI-1-j] = 1'b1;
                        end
                    end
                    rdq.push_back('{cyc + 1 + i, i});
                    opq.push_back('{cyc + 3 + i, ea, eb});
                    wrq.push_back('{cyc + L + 4 + i, i, downstream(ea, eb, exp_k, exp_op), em});
                end
                doneq.push_back(cyc + L + 4 + CH);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        op_in       = 1'($urandom);
        constant_in = {$urandom, $urandom};
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        rand_inputs();
        tick();
        mon_on = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // Nominal pass with ignored restarts and inputs toggling mid-pass.
        start = 1'b1;
        rand_inputs();
        for (int i = 1; i <= 20; i++) begin
            tick();
            start = (i == 2 || i == 14);
            rand_inputs();
        end
        start = 1'b0;
        repeat (12) tick();

        // Reset in cycle 6 of a pass, then a clean pass afterwards.
        start = 1'b1;
        rand_inputs();
        for (int i = 1; i <= 6; i++) begin
            tick();
            start = 1'b0;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        rand_inputs();
        tick();
        start = 1'b0;
        repeat (25) tick();

        // Random start pulses and input churn.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 5) == 0);
            rand_inputs();
            tick();
        end
        start = 1'b0;
        repeat (30) tick();

        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
